// File: rtl/stdout_uart_tx.sv
// Buffers processor stdout writes in a FIFO and serializes them as 8N1 UART frames.
// Define STDOUT_HEX_EN to send each 32-bit word as 8 uppercase hex digits plus a newline.
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);

`ifdef STDOUT_HEX_EN
  localparam int DW = 32;
`else
  localparam int DW = 8;
`endif
  localparam int                 BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_full;
  logic               r_overflow;
  logic               r_tx;
  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;

  state_t             w_state_next;
  logic [BAUD_W-1:0]  w_baud_next;
  logic [2:0]         w_bit_next;
  logic [7:0]         w_shift_next;
  logic               w_tx_next;
  logic               w_pop;
  logic               w_push;
  logic               w_launch;
  logic [FIFO_AW:0]   w_count_next;
  logic [DW-1:0]      w_head;
  logic [DW-1:0]      w_wr_word;

`ifdef STDOUT_HEX_EN
  logic [3:0]  r_nib;
  logic [31:0] r_word;
  logic [3:0]  w_nib_next;
  logic [31:0] w_word_next;
  logic [3:0]  w_hex_nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // r_nib is the index of the next frame for the current word; 0 means fetch a new word.
  assign w_hex_nib = r_word[5'd31 - {r_nib[2:0], 2'b00} -: 4];
  assign w_wr_word = wr_data;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^wr_data[31:8];
  assign w_wr_word   = wr_data[7:0];
`endif

  assign w_head = r_mem[r_rd_ptr];
  assign w_push = wr_en && !r_full;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: the storage array has no reset; validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      // A full FIFO rejects the write even when a pop happens in the same cycle.
      if (wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    w_launch     = 1'b0;
`ifdef STDOUT_HEX_EN
    w_nib_next   = r_nib;
    w_word_next  = r_word;
`endif
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
`ifdef STDOUT_HEX_EN
        if (r_nib != 4'd0) begin
          w_launch     = 1'b1;
          w_nib_next   = (r_nib == 4'd8) ? 4'd0 : r_nib + 4'd1;
          w_shift_next = (r_nib == 4'd8) ? 8'h0A : hex_ascii(w_hex_nib);
        end else if (r_count != '0) begin
          w_pop        = 1'b1;
          w_launch     = 1'b1;
          w_word_next  = w_head;
          w_nib_next   = 4'd1;
          w_shift_next = hex_ascii(w_head[31:28]);
        end
`else
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_launch     = 1'b1;
          w_shift_next = w_head;
        end
`endif
        if (w_launch) begin
          w_state_next = START;
          w_baud_next  = '0;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        w_tx_next   = 1'b0;
        w_baud_next = r_baud + BAUD_ONE;
        if (r_baud == BAUD_LAST) begin
          w_state_next = DATA;
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_tx_next    = r_shift[0];
        end
      end
      DATA: begin
        w_tx_next   = r_shift[r_bit];
        w_baud_next = r_baud + BAUD_ONE;
        if (r_baud == BAUD_LAST) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_shift[r_bit + 3'd1];
          end
        end
      end
      STOP: begin
        w_tx_next   = 1'b1;
        w_baud_next = r_baud + BAUD_ONE;
        if (r_baud == BAUD_LAST) begin
          w_state_next = IDLE;
          w_baud_next  = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef STDOUT_HEX_EN
      r_nib   <= '0;
      r_word  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
`ifdef STDOUT_HEX_EN
      r_nib   <= w_nib_next;
      r_word  <= w_word_next;
`endif
    end
  end

  assign tx         = r_tx;
  assign fifo_full  = r_full;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
`ifdef STDOUT_HEX_EN
  assign busy = (r_state != IDLE) || (r_count != '0) || (r_nib != 4'd0);
`else
  assign busy = (r_state != IDLE) || (r_count != '0);
`endif

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Self-checking bench for stdout_uart_tx: frame-level reference model, every output checked each cycle.
module tb_stdout_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 10 * CPB;
`ifdef STDOUT_HEX_EN
  localparam int FPW = 9;
`else
  localparam int FPW = 1;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          tx;
  logic          busy;
  logic          fifo_full;
  logic          overflow;
  logic [AW:0]   fifo_count;

  stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queued words, scheduled frames (start cycle + byte), line-free cycle.
  logic [31:0] m_q[$];
  int          f_start[$];
  logic [7:0]  f_byte[$];
  int          m_free = 0;
  bit          m_ovf  = 1'b0;
  int          total  = 0;
  int          bad    = 0;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'(48 + int'(n)) : 8'(55 + int'(n));
  endfunction

  function automatic logic tx_exp(input int t);
    int k;
    if (f_start.size() == 0 || t < f_start[0]) return 1'b1;
    k = (t - f_start[0]) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return f_byte[0][k-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // A popped word becomes FPW frames, each one idle cycle after the previous frame's stop bit.
  task automatic launch(input int c, input logic [31:0] w);
    for (int i = 0; i < FPW; i++) begin
      f_start.push_back(c + 1 + i * (FRAME + 1));
      if (FPW == 1)           f_byte.push_back(w[7:0]);
      else if (i == FPW - 1)  f_byte.push_back(8'h0A);
      else                    f_byte.push_back(hex_char(w[31 - 4*i -: 4]));
    end
    m_free = c + FPW * (FRAME + 1);
  endtask

  // Drive one cycle of inputs, advance the model, then check all outputs after the edge.
  task automatic tick(input logic rv, input logic we, input logic [31:0] d);
    int c;
    bit full;
    c       = cyc;
    rst_n   = rv;
    wr_en   = we;
    wr_data = d;
    if (!rv) begin
      m_q.delete();
      f_start.delete();
      f_byte.delete();
      m_free = 0;
      m_ovf  = 1'b0;
    end else begin
      full = (m_q.size() == DEPTH);
      if (m_q.size() > 0 && c >= m_free) launch(c, m_q.pop_front());
      if (we && full)  m_ovf = 1'b1;
      if (we && !full) m_q.push_back(d);
    end
    @(negedge clk);
    while (f_start.size() > 0 && cyc >= f_start[0] + FRAME) begin
      void'(f_start.pop_front());
      void'(f_byte.pop_front());
    end
    check("tx",         32'(tx),         32'(tx_exp(cyc)));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("busy",       32'(busy),       32'(m_q.size() != 0 || cyc < m_free));
  endtask

  task automatic drain();
    for (int n = 0; n < 20000; n++) begin
      if (m_q.size() == 0 && cyc >= m_free) break;
      tick(1'b1, 1'b0, '0);
    end
    repeat (3) tick(1'b1, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] r;
    int          s;
    @(negedge clk);
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);

    // Single 0x55 byte: latency, bit order, stop bit, busy fall.
    tick(1'b1, 1'b1, 32'h0000_0055);
    drain();

    // Upper word bits ignored in byte mode.
    tick(1'b1, 1'b1, 32'h1234_5641);
    drain();

    // 20 back-to-back writes of 0..19: fill to 16, drop the rest, overflow sticks.
    for (int i = 0; i < 20; i++) begin
      r = $urandom();
      tick(1'b1, 1'b1, {r[31:8], 8'(i)});
    end
    repeat (5) tick(1'b1, 1'b0, '0);
    drain();

    // Keep the FIFO full across a pop so a write collides with the pop.
    for (int i = 0; i < 18 + FPW * (FRAME + 1) + 10; i++) tick(1'b1, 1'b1, $urandom());
    drain();

    // Reset during data bit 3 with 5 entries queued.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, $urandom());
    s = f_start[0];
    for (int n = 0; n < 1000 && cyc < s + 4 * CPB + 1; n++) tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    repeat (60) tick(1'b1, 1'b0, '0);

    // Random write traffic.
    for (int i = 0; i < 1500; i++) tick(1'b1, ($urandom_range(0, 7) == 0), $urandom());
    drain();

    // 0xDEADBEEF: one 0xEF frame in byte mode, nine hex/newline frames in hex mode.
    tick(1'b1, 1'b1, 32'hDEAD_BEEF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stdout_uart_tx.md
Name: stdout_uart_tx

Overview:
- Consumer end of the processor's memory-mapped stdout path. The data memory produces a stdout word plus a write strobe; this block buffers those writes in a FIFO and serializes them on a UART TX line (8N1) toward a host terminal.
- Sits beside the data memory in the processor top and runs on the fast system clock.
- Decouples single-cycle stdout stores from the much slower serial line.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2.
- FIFO_AW, 4: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  stdout write strobe, one entry pushed per asserted cycle.
- wr_data  input  32  stdout word written by the processor.
- tx  output  1  UART serial output, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.
- fifo_count  output  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n low at a clk edge): tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0, FSM=IDLE, pointers and baud counter cleared.
  - Reset mid-frame abandons the frame; tx is 1 from the cycle after the reset edge.
- FIFO push: wr_en=1 and fifo_count<FIFO_DEPTH at the edge; the entry is stored and fifo_count increments.
- Full: wr_en=1 with fifo_count==FIFO_DEPTH drops the write and sets overflow. This holds even if a pop happens in the same cycle; there is no pass-through.
- Simultaneous push and pop when not full: both occur and fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_full is (fifo_count==FIFO_DEPTH), registered consistently with fifo_count.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is a registered output. Frame period is 10*CLKS_PER_BIT+1 cycles, because IDLE lasts one cycle between back-to-back frames.
- Latency: with FIFO empty and FSM IDLE, wr_en high in cycle N gives tx=0 from cycle N+2.
- busy = (FSM!=IDLE) or (fifo_count!=0).
- Byte mode (default): the FIFO entry is wr_data[7:0]; wr_data[31:8] is ignored.
- overflow clears only on reset.

Optional Feature:
- Macro STDOUT_HEX_EN.
- Defined:
  - The FIFO stores full 32-bit words.
  - Each popped word is sent as 9 frames: 8 ASCII uppercase hex digits, most-significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0A.
  - A nibble counter (0..8) sequences the frames. IDLE pops the next word only after the 0x0A frame's STOP completes.
  - busy stays high across all 9 frames.
- Undefined: byte mode as above, with an 8-bit-wide FIFO and no nibble logic.

Test Plan:
- Byte mode, CLKS_PER_BIT=4. Release reset, then wr_en=1 for one cycle with wr_data=0x00000055 -> tx=0 from N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop 1 for 4 cycles; busy falls after STOP; overflow=0.
- wr_data=0x12345641 -> exactly one frame carrying 0x41; bits 31:8 have no effect.
- FIFO_DEPTH=16, idle, 20 consecutive wr_en cycles with data 0..19 -> fifo_count reaches 16 and fifo_full=1; writes 17, 18, 19 are dropped; overflow=1 and stays 1; the line carries exactly 17 bytes 0..16 in order.
- FIFO full while the FSM pops in the same cycle as wr_en=1 -> write rejected, fifo_count becomes 15, overflow=1.
- Assert rst_n=0 during DATA bit 3 of a frame with 5 entries queued -> tx=1 the cycle after the reset edge; fifo_count=0, busy=0, overflow=0; no further frames.
- STDOUT_HEX_EN defined, write 0xDEADBEEF -> frames 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46,0x0A back-to-back; busy high throughout, then 0.
